// File: rtl/sbox_trace_pkg.sv
// Shared types and constants for the S-box trace UART.
// Frame length depends on SBOX_TRACE_SYNC_HEADER_EN (see sbox_trace_uart).
package sbox_trace_pkg;

  localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
  localparam int unsigned PAYLOAD_BYTES   = 8;
  localparam int unsigned HDR_FRAME_BYTES = 9;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TRIG_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [31:0] pt;
    logic [31:0] ct;
  } capture_t;

  // Byte k of the capture, most significant byte of pt first.
  function automatic logic [7:0] payload_byte(input capture_t cap, input logic [2:0] k);
    logic [63:0] flat;
    flat = cap;
    return flat[{~k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sbox_trace_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// done_c marks the last cycle of the stop bit; a start there chains with no gap.
module uart_tx_byte
  import sbox_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done_c
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    done_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          cnt_d   = RELOAD;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          done_c = 1'b1;
          if (start) begin
            state_d = ST_START;
            cnt_d   = RELOAD;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/sbox_trace_uart.sv
// Captures an S-box run (pt, ct) and streams it as a UART frame with a scope trigger.
// Define SBOX_TRACE_SYNC_HEADER_EN to prefix each frame with SYNC_BYTE.
module sbox_trace_uart
  import sbox_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TRIG_LEN     = 8
) (
  input  logic        ICE_CLK,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pt,
  input  logic [31:0] in_ct,
  output logic        in_ready,
  output logic        uart_tx,
  output logic        trig,
  output logic        busy,
  output logic        overrun
);

`ifdef SBOX_TRACE_SYNC_HEADER_EN
  localparam int unsigned FRAME_BYTES = HDR_FRAME_BYTES;
`else
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES;
`endif

  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  capture_t          shadow_q, shadow_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic              trig_q, trig_d;
  logic              overrun_q, overrun_d;
  logic              accept_c;
  logic              byte_start_c;
  logic [7:0]        byte_data_c;
  logic [7:0]        next_byte_c;
  logic              byte_done_c;

  always_ff @(posedge ICE_CLK) begin
    if (rst) begin
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      idx_q      <= '0;
      shadow_q   <= '0;
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
      overrun_q  <= overrun_d;
    end
  end

  // idx_q counts frame bytes already handed to the serializer.
`ifdef SBOX_TRACE_SYNC_HEADER_EN
  assign next_byte_c = payload_byte(shadow_q, 3'(idx_q - IDX_W'(1)));
`else
  assign next_byte_c = payload_byte(shadow_q, 3'(idx_q));
`endif

  assign accept_c = in_valid & in_ready_q;

  always_comb begin
    busy_d       = busy_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    trig_cnt_d   = trig_cnt_q;
    trig_d       = 1'b0;
    overrun_d    = overrun_q | (in_valid & ~in_ready_q);
    byte_start_c = 1'b0;
    byte_data_c  = 8'h00;

    if (accept_c) begin
      trig_d     = 1'b1;
      trig_cnt_d = TRIG_W'(TRIG_LEN - 1);
    end else if (trig_cnt_q != '0) begin
      trig_d     = 1'b1;
      trig_cnt_d = trig_cnt_q - TRIG_W'(1);
    end

    if (accept_c) begin
      shadow_d     = '{pt: in_pt, ct: in_ct};
      busy_d       = 1'b1;
      idx_d        = IDX_W'(1);
      byte_start_c = 1'b1;
`ifdef SBOX_TRACE_SYNC_HEADER_EN
      byte_data_c  = SYNC_BYTE;
`else
      byte_data_c  = in_pt[31:24];
`endif
    end else if (busy_q && byte_done_c) begin
      if (idx_q == IDX_W'(FRAME_BYTES)) begin
        busy_d = 1'b0;
      end else begin
        byte_start_c = 1'b1;
        byte_data_c  = next_byte_c;
        idx_d        = idx_q + IDX_W'(1);
      end
    end

    in_ready_d = ~busy_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (ICE_CLK),
    .rst    (rst),
    .start  (byte_start_c),
    .data   (byte_data_c),
    .tx     (uart_tx),
    .done_c (byte_done_c)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign trig     = trig_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/sbox_trace_uart.md
SBOX_TRACE_UART -- requirements
Module: sbox_trace_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, ICE_CLK cycles per UART bit (12 MHz / 115200); legal range 2..65535.
REQ-002 Parameter TRIG_LEN, default 8, width in cycles of the scope-trigger pulse; legal range 1..255.
REQ-003 ICE_CLK  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  in_pt/in_ct hold a completed S-box run (one-cycle or held).
REQ-006 in_pt  input  32  LFSR-derived plaintext word that started the run.
REQ-007 in_ct  input  32  final S-box chain result word.
REQ-008 in_ready  output  1  high when the block can accept a new word pair.
REQ-009 uart_tx  output  1  8N1 serial line, idle high.
REQ-010 trig  output  1  scope-trigger pulse marking an accepted capture.
REQ-011 busy  output  1  frame transmission in progress (inverse of in_ready).
REQ-012 overrun  output  1  sticky flag: in_valid seen while not ready.

Function
REQ-013 Acceptance occurs on a cycle where in_valid and in_ready are both high; in_pt and in_ct are latched into an internal 64-bit shadow register that cycle.
REQ-014 in_ready is high only in state IDLE and falls the cycle after acceptance.
REQ-015 States: IDLE -> START (on accept) -> DATA (8 bits) -> STOP -> START for next byte, or IDLE after the last byte's stop bit.
REQ-016 Each of START, each DATA bit, and STOP lasts exactly CLKS_PER_BIT cycles, timed by a bit counter reloaded on every bit boundary.
REQ-017 uart_tx is registered; it drives low in the cycle after acceptance (one-cycle latency).
REQ-018 Payload byte order: in_pt[31:24], [23:16], [15:8], [7:0], then in_ct[31:24] .. in_ct[7:0]; each byte sent LSB first.
REQ-019 Without header, total frame = 8 x 10 x CLKS_PER_BIT cycles from uart_tx falling to in_ready rising.
REQ-020 in_ready rises in the cycle after the final stop bit's last cycle; in_valid high in that same cycle is accepted (back-to-back frames, no idle bit inserted).
REQ-021 trig goes high in the cycle after acceptance and stays high exactly TRIG_LEN cycles; it is independent of frame progress.
REQ-022 in_valid high while in_ready low sets overrun; the offered data is dropped and the frame in flight is unaffected.
REQ-023 overrun stays set until reset; it is not cleared by a later acceptance.
REQ-024 Input changes after acceptance have no effect on the frame in flight.

Reset
REQ-025 While rst is high: state IDLE, uart_tx=1, trig=0, busy=0, in_ready=0, overrun=0, counters and shadow register zero.
REQ-026 in_ready rises the first cycle after rst deasserts.
REQ-027 rst asserted mid-frame aborts immediately; uart_tx returns high the next cycle and no partial byte resumes.

Configuration
REQ-028 Macro SBOX_TRACE_SYNC_HEADER_EN defined: every frame is prefixed by one sync byte 8'hA5 before in_pt[31:24], giving 9 bytes (90 x CLKS_PER_BIT cycles).
REQ-029 Macro undefined: no sync byte; frames are exactly 8 bytes; no header logic is synthesised.

Structure
REQ-030 Shared package sbox_trace_pkg holds the state enumeration, SYNC_BYTE = 8'hA5, and payload byte-count constants (8, 9).
REQ-031 Single sub-module uart_tx_byte: takes a byte plus start strobe, produces start/8 data/stop bits and a done pulse; the top level sequences bytes and owns trig and overrun.

Verification (CLKS_PER_BIT=4, TRIG_LEN=3 unless noted)
REQ-032 in_pt=32'h01234567, in_ct=32'hDEADBEEF, single in_valid pulse -> decoded bytes 01 23 45 67 DE AD BE EF, in_ready high again after 320 cycles.
REQ-033 Same stimulus with SBOX_TRACE_SYNC_HEADER_EN -> bytes A5 01 23 45 67 DE AD BE EF, 360 cycles.
REQ-034 Acceptance -> trig high exactly cycles 1..3 after acceptance; uart_tx low from cycle 1, for 4 cycles.
REQ-035 in_valid pulsed 50 cycles into a frame -> overrun=1 and stays 1; frame bytes unchanged; a second frame accepted afterwards leaves overrun=1.
REQ-036 in_valid held continuously with new data ready -> second frame starts in the cycle after in_ready rises, no gap between stop bit and next start bit.
REQ-037 rst pulsed at cycle 100 of a frame -> uart_tx=1, busy=0, overrun=0 next cycle; fresh frame afterwards decodes correctly.
